// File: rtl/tri_mon_pkg.sv
// Shared types and defaults for the triangle sweep monitor.
// The error counter is only built when TRI_MON_ERRCNT_EN is defined.
package tri_mon_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACQUIRE,
    ST_LOCKED
  } mon_state_e;

  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned DEF_LOCK_LEN = 4;
  localparam int unsigned PERIOD_W     = 16;
  localparam int unsigned ERRCNT_W     = 8;

endpackage

// File: rtl/tri_sweep_monitor_if.sv
// Sweep stream from the generator: counter value plus direction.
interface tri_sweep_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] counter;
  logic             mode;

  modport master (output counter, output mode);
  modport slave  (input  counter, input  mode);
endinterface

// File: rtl/tri_next_pred.sv
// Combinational successor of a triangle sweep sample (c, m) -> (c', m').
module tri_next_pred #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             mode,
  output logic [WIDTH-1:0] nxt_cnt,
  output logic             nxt_mode
);

  localparam logic [WIDTH-1:0] MAX = '1;

  always_comb begin
    nxt_cnt  = cnt;
    nxt_mode = mode;
    if (!mode) begin
      if (cnt == MAX) nxt_mode = 1'b1;
      else            nxt_cnt  = cnt + 1'b1;
    end else begin
      if (cnt == '0)  nxt_mode = 1'b0;
      else            nxt_cnt  = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/tri_sweep_monitor.sv
// Lock/peak/trough/error checker for the triangle sweep stream.
// Optional err_count port and register under `define TRI_MON_ERRCNT_EN.
module tri_sweep_monitor
  import tri_mon_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_LEN = DEF_LOCK_LEN
) (
  input  logic                clk_1,
  input  logic                rst,
  tri_sweep_if.slave          sw,
  input  logic                clr_err,
  output logic                locked,
  output logic                peak_p,
  output logic                trough_p,
  output logic                err_p,
  output logic                err_sticky,
  output logic [PERIOD_W-1:0] period_cnt
`ifdef TRI_MON_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  localparam logic [WIDTH-1:0] MAX        = '1;
  localparam logic [4:0]       LOCK_LEN_V = 5'(LOCK_LEN);

  mon_state_e       state;
  logic [3:0]       run;
  logic [WIDTH-1:0] prev_cnt;
  logic             prev_mode;
  logic [WIDTH-1:0] pred_cnt;
  logic             pred_mode;
  logic             match;
  logic             new_err;

  tri_next_pred #(.WIDTH(WIDTH)) u_pred (
    .cnt      (prev_cnt),
    .mode     (prev_mode),
    .nxt_cnt  (pred_cnt),
    .nxt_mode (pred_mode)
  );

  assign match   = (sw.counter == pred_cnt) && (sw.mode == pred_mode);
  assign new_err = (state == ST_LOCKED) && !match;

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state      <= ST_EMPTY;
      run        <= '0;
      prev_cnt   <= '0;
      prev_mode  <= 1'b0;
      locked     <= 1'b0;
      peak_p     <= 1'b0;
      trough_p   <= 1'b0;
      err_p      <= 1'b0;
      err_sticky <= 1'b0;
      period_cnt <= '0;
    end else begin
      prev_cnt  <= sw.counter;
      prev_mode <= sw.mode;
      peak_p    <= 1'b0;
      trough_p  <= 1'b0;
      err_p     <= 1'b0;
      // A new error overrides a simultaneous clear.
      if (new_err)      err_sticky <= 1'b1;
      else if (clr_err) err_sticky <= 1'b0;

      case (state)
        ST_EMPTY: begin
          state <= ST_ACQUIRE;
          run   <= '0;
        end
        ST_ACQUIRE: begin
          if (!match) begin
            run <= '0;
          end else if ({1'b0, run} + 5'd1 == LOCK_LEN_V) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
            run    <= '0;
          end else begin
            run <= run + 4'd1;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            if (sw.counter == MAX && sw.mode)  peak_p <= 1'b1;
            if (sw.counter == '0 && !sw.mode) begin
              trough_p   <= 1'b1;
              period_cnt <= period_cnt + 1'b1;
            end
          end else begin
            err_p  <= 1'b1;
            state  <= ST_ACQUIRE;
            locked <= 1'b0;
            run    <= '0;
          end
        end
        default: begin
          state  <= ST_EMPTY;
          locked <= 1'b0;
          run    <= '0;
        end
      endcase
    end
  end

`ifdef TRI_MON_ERRCNT_EN
  always_ff @(posedge clk_1) begin
    if (rst) begin
      err_count <= '0;
    end else if (new_err) begin
      if (clr_err)             err_count <= ERRCNT_W'(1);
      else if (err_count != '1) err_count <= err_count + 1'b1;
    end else if (clr_err) begin
      err_count <= '0;
    end
  end
`endif

endmodule

// File: doc/tri_sweep_monitor.md
# tri_sweep_monitor

Receive-side checker for the triangle sweep stream (4-bit up/down counter plus direction `mode`) produced by the sweep generator. Samples `counter`/`mode` every `clk_1` cycle, predicts the next legal pair, acquires lock after a run of correct predictions, then reports peak/trough events, completed periods and protocol errors. Sits directly downstream of the generator in the same clock domain; feeds status LEDs and the debug register block.

## Interface
- `WIDTH`, 4, sweep counter width; `MAX` = 2^WIDTH−1
- `LOCK_LEN`, 4, consecutive matching samples required to lock (1..15)

- `clk_1`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `counter`  in  WIDTH  sweep value from generator
- `mode`  in  1  sweep direction: 0 = rising, 1 = falling
- `clr_err`  in  1  synchronous clear of `err_sticky` (and `err_count`)
- `locked`  out  1  high while in LOCKED
- `peak_p`  out  1  one-cycle pulse, peak turnaround seen while locked
- `trough_p`  out  1  one-cycle pulse, trough turnaround seen while locked
- `err_p`  out  1  one-cycle pulse, mismatch while locked
- `err_sticky`  out  1  set by `err_p`, held until `clr_err`
- `period_cnt`  out  16  completed sweep periods since reset
- `err_count`  out  8  only with `TRI_MON_ERRCNT_EN`

## Operation
- Legal successor of (c, m): m=0, c≠MAX → (c+1, 0); m=0, c=MAX → (MAX, 1); m=1, c≠0 → (c−1, 1); m=1, c=0 → (0, 0). Period = 2·(MAX+1) = 32 cycles at WIDTH=4; each extreme appears once per mode.
- Registers `prev_cnt`, `prev_mode` always load the current sample (resync on every edge).
- States:
  - EMPTY: no previous sample. Next edge → ACQUIRE, `run` = 0.
  - ACQUIRE: match → `run`+1; `run`+1 = LOCK_LEN → LOCKED. Mismatch → `run` = 0, no error reported.
  - LOCKED: match → stay. Mismatch → `err_p`, `err_sticky` = 1, → ACQUIRE, `run` = 0.
- Events only when state was LOCKED before the edge and the sample matched:
  - peak: sample = (MAX, 1) → `peak_p`
  - trough: sample = (0, 0) → `trough_p`, `period_cnt` + 1 (wraps 16'hFFFF → 0)
- `clr_err` with a simultaneous new error: error wins, `err_sticky` stays 1.
- Counter input values out of range cannot occur (width-limited); any illegal step is a mismatch.

## Timing
- All outputs registered; one-cycle latency: sample presented in cycle n → outputs valid in cycle n+1.
- Reset: state = EMPTY, `run` = 0, `prev_*` = 0, all outputs 0. `rst` mid-operation drops `locked` on the next edge and discards `period_cnt`, `err_sticky`, `err_count`.
- First lock from clean stream after reset release: sample 0 fills EMPTY, samples 1..LOCK_LEN match → `locked` high in cycle LOCK_LEN+1 (cycle 5 at defaults).
- `peak_p`/`trough_p`/`err_p` never high together; never high two consecutive cycles except `err_p` is impossible back-to-back (state leaves LOCKED).

## Configuration
- `TRI_MON_ERRCNT_EN` defined: `err_count` port present; increments on each `err_p`, saturates at 255, cleared by `clr_err` (increment wins over clear in the same cycle → value 1) and by `rst`.
- Not defined: no `err_count` port or register; all other behaviour identical.

## Structure
- Package `tri_mon_pkg`: state enum (EMPTY, ACQUIRE, LOCKED), default `WIDTH`/`LOCK_LEN` constants, period counter width.
- Sub-module `tri_next_pred`: combinational successor function (c, m) → (c', m'), parameterised by `WIDTH`; reused by the generator's bench model.

## Test plan
- Clean stream from reset (0,0),(1,0)… → `locked` rises cycle 5; (15,1) at cycle 16 → `peak_p` cycle 17; (0,0) at cycle 32 → `trough_p` cycle 33, `period_cnt` = 1.
- Locked, inject (7,0) where (6,0) expected → `err_p` one cycle, `err_sticky` = 1, `locked` low next cycle; resumes lock after 4 clean samples, `err_sticky` still 1.
- Glitch during ACQUIRE (before lock) → no `err_p`, `run` restarts, lock delayed accordingly.
- `clr_err` pulse alone → `err_sticky` 0; `clr_err` same cycle as error → `err_sticky` 1.
- `rst` asserted mid-sweep while locked with `period_cnt` = 3 → next cycle all outputs 0, state EMPTY.
- With `TRI_MON_ERRCNT_EN`: 260 forced errors (relock between each) → `err_count` = 255; `clr_err` → 0.
